// File: rtl/bsk_prd_pkg.sv
// Shared constants and address-map helpers for the BSK command-receiver board.
package bsk_prd_pkg;

   localparam logic [6:0] VERSION = 7'h40;

   localparam int CTRL_TEST_EN_BIT = 0;
   localparam int CTRL_VER_LSB     = 1;
   localparam int CTRL_ID_LSB      = 8;

   // Command words always open the map; the argument keeps the helper family uniform.
   function automatic int cmd_base(input int n_com);
      return 0 * n_com;
   endfunction

   function automatic int ind_base(input int n_com);
      return n_com / 8;
   endfunction

   function automatic int ctrl_addr(input int n_com);
      return n_com / 8 + n_com / 16;
   endfunction

   // c is the active-high command group; each nibble is paired with its complement.
   function automatic logic [15:0] cmd_word(input logic [7:0] c);
      return {~c[7:4], c[7:4], ~c[3:0], c[3:0]};
   endfunction

endpackage

// File: rtl/bsk_prd_filt_if.sv
// Asynchronous 16-bit backplane bus as seen by one board.
interface bsk_prd_filt_if #(parameter int AW = 4);
   logic [3:0]    iCS;
   logic [AW-1:0] iA;
   logic          iRd_n;
   logic          iWr_n;
   logic [15:0]   iD;
   logic [15:0]   oD;
   logic          oD_oe;

   modport master (output iCS, iA, iRd_n, iWr_n, iD, input oD, oD_oe);
   modport slave  (input iCS, iA, iRd_n, iWr_n, iD, output oD, oD_oe);
endinterface

// File: rtl/bsk_com_filter.sv
// One command channel: 2-FF resync then a debounce that toggles state after
// FILT_CYC consecutive disagreeing samples.
module bsk_com_filter #(
   parameter int FILT_CYC = 8
) (
   input  logic clk,
   input  logic aclr,
   input  logic com_n,
   output logic state
);
   localparam int CW = $clog2(FILT_CYC + 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         sync  <= 2'b11;
         state <= 1'b1;
         cnt   <= '0;
      end else begin
         sync <= {sync[0], com_n};
         if (sync[1] == state) begin
            cnt <= '0;
         end else if (cnt == CW'(FILT_CYC - 1)) begin
            state <= ~state;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/bsk_prd_filt.sv
// Command-receiver board controller: debounced command inputs, indication and control
// registers on the async backplane bus. Define BSK_PRD_TEST_EN to enable the test-signal gate.
module bsk_prd_filt
   import bsk_prd_pkg::*;
#(
   parameter int         N_COM     = 16,
   parameter int         FILT_CYC  = 8,
   parameter logic [3:0] CS_CODE   = 4'b1011,
   parameter logic [7:0] UNIT_CODE = 8'hA4,
   parameter int         AW        = 4
) (
   input  logic                 clk,
   input  logic                 aclr,
   input  logic                 unit,
   bsk_prd_filt_if.slave        bus,
   input  logic [N_COM-1:0]     iCom_n,
   output logic [N_COM-1:0]     oComInd_n,
   output logic                 oCS_n,
   input  logic                 iBl,
   input  logic                 iTest,
   output logic                 oTest
);
   localparam int NW   = N_COM / 8;
   localparam int NI   = N_COM / 16;
   localparam int CMD  = cmd_base(N_COM);
   localparam int IND  = ind_base(N_COM);
   localparam int CTRL = ctrl_addr(N_COM);

   logic [N_COM-1:0] com_state;
   logic [N_COM-1:0] com_ind;
   logic             cs;
   logic [7:0]       unit_id;
   logic [15:0]      rd_dat;
   logic             test_en;

   logic [1:0]       wr_sync;
   logic             wr_s;
   logic             wr_d;
   logic [1:0]       sync_vld;
   logic             armed;
   logic             cap_cs;
   logic [AW-1:0]    cap_a;
   logic [15:0]      cap_d;
   logic             commit;

   for (genvar i = 0; i < N_COM; i++) begin : g_com
      bsk_com_filter #(.FILT_CYC(FILT_CYC)) u_filt (
         .clk   (clk),
         .aclr  (aclr),
         .com_n (iCom_n[i]),
         .state (com_state[i])
      );
   end

   assign cs      = (bus.iCS == {CS_CODE[3:2], ~unit, CS_CODE[0]});
   assign oCS_n   = ~cs;
   assign unit_id = UNIT_CODE + {7'd0, unit};

   assign wr_s   = wr_sync[1];
   assign commit = wr_s && !wr_d && cap_cs;

   // A write only counts once a real idle-high strobe has been seen through the
   // synchroniser, so a low phase straddling reset is dropped rather than committed.
   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         wr_sync  <= 2'b11;
         wr_d     <= 1'b1;
         sync_vld <= 2'b00;
         armed    <= 1'b0;
         cap_cs   <= 1'b0;
         cap_a    <= '0;
         cap_d    <= '0;
         com_ind  <= '0;
      end else begin
         wr_sync  <= {wr_sync[0], bus.iWr_n};
         wr_d     <= wr_s;
         sync_vld <= {sync_vld[0], 1'b1};
         if (sync_vld[1] && wr_s)
            armed <= 1'b1;
         if (!wr_s && armed) begin
            cap_cs <= cs;
            cap_a  <= bus.iA;
            cap_d  <= bus.iD;
         end
         for (int j = 0; j < NI; j++) begin
            if (commit && cap_a == AW'(IND + j))
               com_ind[16*j +: 16] <= cap_d;
         end
      end
   end

`ifdef BSK_PRD_TEST_EN
   always_ff @(posedge clk or posedge aclr) begin
      if (aclr)
         test_en <= 1'b0;
      else if (commit && cap_a == AW'(CTRL))
         test_en <= cap_d[CTRL_TEST_EN_BIT];
   end
`else
   assign test_en = 1'b0;
`endif

   always_comb begin
      rd_dat = '0;
      for (int k = 0; k < NW; k++) begin
         if (bus.iA == AW'(CMD + k))
            rd_dat = cmd_word(~com_state[8*k +: 8]);
      end
      for (int j = 0; j < NI; j++) begin
         if (bus.iA == AW'(IND + j))
            rd_dat = com_ind[16*j +: 16];
      end
      if (bus.iA == AW'(CTRL)) begin
         rd_dat[15:CTRL_ID_LSB]                = unit_id;
         rd_dat[CTRL_ID_LSB-1:CTRL_VER_LSB]    = VERSION;
         rd_dat[CTRL_TEST_EN_BIT]              = test_en;
      end
   end

   assign bus.oD    = rd_dat;
   assign bus.oD_oe = cs && !bus.iRd_n;
   assign oComInd_n = ~com_ind;
   assign oTest     = iTest && test_en && !iBl;

endmodule

// File: tb/tb_bsk_prd_filt.sv
// Directed bench for bsk_prd_filt: N_COM=32, FILT_CYC=8, unit=1.
module tb_bsk_prd_filt;
   localparam int N_COM    = 32;
   localparam int FILT_CYC = 8;
   localparam int AW       = 4;
   localparam logic [3:0] CS_OK  = 4'b1001;
   localparam logic [3:0] CS_BAD = 4'b1011;
`ifdef BSK_PRD_TEST_EN
   localparam logic TE_EXP = 1'b1;
`else
   localparam logic TE_EXP = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             aclr;
   logic             unit;
   logic [N_COM-1:0] iCom_n;
   logic [N_COM-1:0] oComInd_n;
   logic             oCS_n;
   logic             iBl;
   logic             iTest;
   logic             oTest;

   bsk_prd_filt_if #(.AW(AW)) bus ();

   bsk_prd_filt #(
      .N_COM    (N_COM),
      .FILT_CYC (FILT_CYC),
      .CS_CODE  (4'b1011),
      .UNIT_CODE(8'hA4),
      .AW       (AW)
   ) dut (
      .clk       (clk),
      .aclr      (aclr),
      .unit      (unit),
      .bus       (bus),
      .iCom_n    (iCom_n),
      .oComInd_n (oComInd_n),
      .oCS_n     (oCS_n),
      .iBl       (iBl),
      .iTest     (iTest),
      .oTest     (oTest)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic rd(input logic [3:0] a, input string nm, input logic [15:0] exp);
      @(negedge clk);
      bus.iCS   = CS_OK;
      bus.iA    = a;
      bus.iRd_n = 1'b0;
      #1 chk(nm, {16'd0, bus.oD}, {16'd0, exp});
   endtask

   // Drives the strobe low for 4 clk; returns at the negedge where it is raised.
   task automatic wr(input logic [3:0] c, input logic [3:0] a, input logic [15:0] d,
                     input logic rd_n);
      @(negedge clk);
      bus.iCS   = c;
      bus.iA    = a;
      bus.iD    = d;
      bus.iRd_n = rd_n;
      bus.iWr_n = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      bus.iWr_n = 1'b1;
   endtask

   task automatic settle();
      repeat (5) @(posedge clk);
   endtask

   typedef struct {
      logic [3:0]  cs;
      logic [3:0]  a;
      logic        rd_n;
      logic [15:0] d;
      logic        oe;
      logic        csn;
   } rd_vec_t;

   rd_vec_t tbl [11];
   int      glitch_len [2];

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0]  = '{CS_OK,  4'd0,  1'b0, 16'hF0F0, 1'b1, 1'b0};
      tbl[1]  = '{CS_OK,  4'd1,  1'b0, 16'hF0D2, 1'b1, 1'b0};
      tbl[2]  = '{CS_OK,  4'd2,  1'b0, 16'hF0F0, 1'b1, 1'b0};
      tbl[3]  = '{CS_OK,  4'd3,  1'b0, 16'h0FF0, 1'b1, 1'b0};
      tbl[4]  = '{CS_OK,  4'd4,  1'b0, 16'h0000, 1'b1, 1'b0};
      tbl[5]  = '{CS_OK,  4'd5,  1'b0, 16'h0000, 1'b1, 1'b0};
      tbl[6]  = '{CS_OK,  4'd6,  1'b0, 16'hA580, 1'b1, 1'b0};
      tbl[7]  = '{CS_OK,  4'd7,  1'b0, 16'h0000, 1'b1, 1'b0};
      tbl[8]  = '{CS_OK,  4'd15, 1'b0, 16'h0000, 1'b1, 1'b0};
      tbl[9]  = '{CS_OK,  4'd1,  1'b1, 16'hF0D2, 1'b0, 1'b0};
      tbl[10] = '{CS_BAD, 4'd1,  1'b0, 16'hF0D2, 1'b0, 1'b1};
      glitch_len[0] = 5;
      glitch_len[1] = FILT_CYC - 1;

      aclr      = 1'b1;
      unit      = 1'b1;
      iCom_n    = '0;
      iBl       = 1'b0;
      iTest     = 1'b1;
      bus.iCS   = CS_OK;
      bus.iA    = '0;
      bus.iRd_n = 1'b0;
      bus.iWr_n = 1'b1;
      bus.iD    = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_word0", {16'd0, bus.oD}, 32'h0000_F0F0);
      chk("rst_ind", oComInd_n, 32'hFFFF_FFFF);
      chk("rst_otest", {31'd0, oTest}, 32'd0);
      chk("rst_oe", {31'd0, bus.oD_oe}, 32'd1);

      // Release reset with all commands active; state flips at edge FILT_CYC+2.
      @(negedge clk);
      aclr = 1'b0;
      repeat (FILT_CYC + 1) @(posedge clk);
      #1 chk("lat_pre", {16'd0, bus.oD}, 32'h0000_F0F0);
      @(posedge clk);
      #1 chk("lat_hit", {16'd0, bus.oD}, 32'h0000_0F0F);

      @(negedge clk);
      iCom_n = '1;
      repeat (15) @(posedge clk);
      rd(4'd0, "idle_word0", 16'hF0F0);

      foreach (glitch_len[g]) begin
         @(negedge clk);
         iCom_n[9] = 1'b0;
         repeat (glitch_len[g]) @(posedge clk);
         @(negedge clk);
         iCom_n[9] = 1'b1;
         repeat (15) @(posedge clk);
         rd(4'd1, $sformatf("glitch%0d", glitch_len[g]), 16'hF0F0);
      end

      @(negedge clk);
      iCom_n[9] = 1'b0;
      repeat (FILT_CYC + 1) @(posedge clk);
      #1 chk("hold_pre", {16'd0, bus.oD}, 32'h0000_F0F0);
      @(posedge clk);
      #1 chk("hold_hit", {16'd0, bus.oD}, 32'h0000_F0D2);

      @(negedge clk);
      iCom_n = 32'h0FFF_FDFF;
      repeat (15) @(posedge clk);
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         bus.iCS   = tbl[i].cs;
         bus.iA    = tbl[i].a;
         bus.iRd_n = tbl[i].rd_n;
         #1;
         chk($sformatf("tbl%0d_d", i), {16'd0, bus.oD}, {16'd0, tbl[i].d});
         chk($sformatf("tbl%0d_oe", i), {31'd0, bus.oD_oe}, {31'd0, tbl[i].oe});
         chk($sformatf("tbl%0d_csn", i), {31'd0, oCS_n}, {31'd0, tbl[i].csn});
      end

      // Indication write with commit-latency bounds around the rising strobe.
      wr(CS_OK, 4'd5, 16'hA5A5, 1'b1);
      @(posedge clk);
      @(posedge clk);
      #1 chk("wr_early", oComInd_n, 32'hFFFF_FFFF);
      @(posedge clk);
      #1 chk("wr_commit", oComInd_n, 32'h5A5A_FFFF);

      wr(CS_BAD, 4'd4, 16'h1234, 1'b1);
      settle();
      chk("wr_badcs", oComInd_n, 32'h5A5A_FFFF);
      wr(CS_OK, 4'd4, 16'h00FF, 1'b1);
      settle();
      chk("wr_word4", oComInd_n, 32'h5A5A_FF00);
      wr(CS_OK, 4'd7, 16'h1111, 1'b1);
      settle();
      wr(CS_OK, 4'd15, 16'h2222, 1'b1);
      settle();
      chk("wr_unmapped", oComInd_n, 32'h5A5A_FF00);
      rd(4'd5, "rd_word5", 16'hA5A5);

      // Read of the word being written shows the old value until commit.
      wr(CS_OK, 4'd5, 16'h0F0F, 1'b0);
      #1 chk("rw_low", {16'd0, bus.oD}, 32'h0000_A5A5);
      @(posedge clk);
      @(posedge clk);
      #1 chk("rw_early", {16'd0, bus.oD}, 32'h0000_A5A5);
      @(posedge clk);
      #1 chk("rw_commit", {16'd0, bus.oD}, 32'h0000_0F0F);

      wr(CS_OK, 4'd6, 16'h0001, 1'b1);
      settle();
      rd(4'd6, "ctrl_rd", {15'h52C0, TE_EXP});
      @(negedge clk);
      iTest = 1'b1;
      #1 chk("otest_hi", {31'd0, oTest}, {31'd0, TE_EXP});
      iTest = 1'b0;
      #1 chk("otest_lo", {31'd0, oTest}, 32'd0);
      iTest = 1'b1;
      iBl   = 1'b1;
      #1 chk("otest_blk", {31'd0, oTest}, 32'd0);
      iBl = 1'b0;

      // Reset lands inside a write low phase; the write must be dropped.
      @(negedge clk);
      iCom_n = '1;
      settle();
      @(negedge clk);
      bus.iCS   = CS_OK;
      bus.iA    = 4'd5;
      bus.iD    = 16'hFFFF;
      bus.iRd_n = 1'b1;
      bus.iWr_n = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      aclr = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      aclr = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      bus.iWr_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("arst_ind", oComInd_n, 32'hFFFF_FFFF);
      chk("arst_otest", {31'd0, oTest}, 32'd0);
      rd(4'd5, "arst_word5", 16'h0000);
      rd(4'd6, "arst_ctrl", 16'hA580);
      rd(4'd0, "arst_word0", 16'hF0F0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/bsk_prd_filt.md
# bsk_prd_filt

Parametrised command-receiver board controller, successor to the 16-channel receiver. Takes N_COM active-low command inputs, resynchronises and debounces each one in the system clock domain, and exposes them to the host over the asynchronous 16-bit parallel bus. Exposes the same bus as the writable indication register, ID/version word and test-signal gate. Sits between the optocoupled command inputs and the backplane bus of the BSK chassis.

## Interface
- N_COM, 16: command channels; multiple of 16, 16..64.
- FILT_CYC, 8: debounce length in clk cycles; ≥1.
- CS_CODE, 4'b1011: chip-select code; bit 1 is replaced by !unit.
- UNIT_CODE, 8'hA4: module ID base; the reported ID is UNIT_CODE + unit.
- AW, 4: bus address width; must satisfy 2^AW ≥ N_COM/8 + N_COM/16 + 1.
- clk  in  1  system clock.
- aclr  in  1  reset, asynchronous, active-high.
- unit  in  1  board position (0 = lower command bank, 1 = upper); static.
- iCS  in  4  chip-select code from the backplane.
- iA  in  AW  word address.
- iRd_n, iWr_n  in  1  read and write strobes, active-low, asynchronous to clk.
- iD  in  16  write data.
- oD  out  16  read data.
- oD_oe  out  1  bus drive enable; the top level builds the tristate.
- iCom_n  in  N_COM  raw command inputs, active-low.
- oComInd_n  out  N_COM  indication LEDs, active-low.
- oCS_n  out  1  chip-select echo, active-low.
- iBl  in  1  block, active-high.
- iTest / oTest  in/out  1  test signal path.

## Operation
- cs = (iCS == {CS_CODE[3:2], !unit, CS_CODE[0]}). cs is combinational. oCS_n = !cs.
- Per channel: a 2-FF synchroniser feeds a filter. The filter holds a state register (reset 1 = inactive) and a counter of width $clog2(FILT_CYC+1).
  - When the synchronised input equals the state, the counter clears.
  - When it differs, the counter increments. On the edge where the counter reaches FILT_CYC-1, the state toggles and the counter clears.
- Address map, with NW = N_COM/8 and NI = N_COM/16:
  - Word k < NW: command group c = state[8k+7:8k], read only. Returned as {~c[7:4], c[7:4], ~c[3:0], c[3:0]}.
  - Words NW..NW+NI-1: indication word j. Read/write. Drives com_ind[16j+15:16j], active-high. oComInd_n = ~com_ind.
  - Word NW+NI: control word {UNIT_CODE+unit, 7'(VERSION), test_en}. Only bit 0 is writable.
  - Every other address reads 16'h0000. Writes to it are ignored.
- Read path is combinational: oD = mux(iA). oD_oe = cs && !iRd_n.
- Write path:
  - iWr_n passes through a 2-FF synchroniser; wr_s is the second stage.
  - On every edge with wr_s = 0, the block captures {cs, iA, iD}.
  - On the edge where wr_s goes 0→1, the block commits the captured write if the captured cs = 1.
- oTest = iTest && test_en && !iBl.

## Timing
- Reset values:
  - Filter states all 1 and counters 0; command words read 16'hF0F0.
  - com_ind = 0, so oComInd_n = all 1.
  - test_en = 0 and oTest = 0.
  - Synchronisers reset to 1.
- Command latency:
  - An input change sampled at edge 1 toggles the state at edge FILT_CYC+2.
  - A glitch shorter than FILT_CYC cycles after the synchroniser is rejected.
- Bus contract:
  - The write low pulse lasts ≥3 clk.
  - iA, iD and iCS stay stable for the whole low phase.
  - The write takes effect 2–3 clk after iWr_n rises.
  - Read data is valid while iRd_n is low. A concurrently changing filter state may change oD; this is accepted.
- Reset during a write aborts the write and leaves the register at its reset value.
- A simultaneous read and write of the same word returns the old value until commit.

## Configuration
- BSK_PRD_TEST_EN defined: test_en is writable and oTest is gated as above.
- BSK_PRD_TEST_EN undefined: test_en is tied 0 and bit 0 of the control word reads 0. Writes to bit 0 are ignored and oTest is constant 0.

## Structure
- Package bsk_prd_pkg holds:
  - VERSION (7'h40);
  - control-word bit positions;
  - functions for the address-offset helpers (cmd_base, ind_base, ctrl_addr) taking N_COM.
- Sub-module bsk_com_filter: synchroniser, counter and state for one channel, parameter FILT_CYC. Generated N_COM times.

## Test plan
- Reset with all iCom_n = 0 → word 0 reads F0F0, oComInd_n = all 1, oTest = 0. After FILT_CYC+2 clk, word 0 reads 0F0F.
- N_COM = 32, unit = 1, FILT_CYC = 8: pulse iCom_n[9] low for 5 clk → no change. Hold it low for 20 clk → word 1 reads 0xF0D2 (FILT_CYC+2 clk after the first sample).
- Write 0xA5A5 to ind word 1 (addr 5, N_COM = 32) with iCS = 4'b1001, unit = 1 → oComInd_n[31:16] = 0x5A5A 2–3 clk after iWr_n rises. The same write with the wrong iCS → no change.
- Read control word, unit = 1 → 0xA5 in [15:8], VERSION in [7:1]. oD_oe is high only while cs && !iRd_n.
- With BSK_PRD_TEST_EN: write 1 to bit 0 of the control word, toggle iTest → oTest follows. Raise iBl → oTest = 0. Without the macro → oTest stays 0 and bit 0 reads 0.
- Assert aclr mid-write-pulse, then release it before iWr_n rises → no commit and all registers at reset values.
